// File: rtl/mio_pkg.sv
// Shared constants for the MIO input conditioning stage.
// Field offsets describe the packed status word read back over the bus.
package mio_pkg;

  localparam int unsigned MIO_NBTN      = 5;
  localparam int unsigned MIO_NSW       = 16;

  localparam int unsigned STAT_SW_LSB   = 0;
  localparam int unsigned STAT_BTN_LSB  = 16;
  localparam int unsigned STAT_FLAG_LSB = 24;

endpackage

// File: rtl/debounce_bit.sv
// One raw input: 2-flop synchroniser, stability counter and accepted level.
// The level flips only after STABLE_CNT consecutive ticks disagree with it.
module debounce_bit #(
  parameter int unsigned STABLE_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CNT);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          stable_q, stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick) begin
      if (sync_q[1] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CntMax) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/mio_input_debounce.sv
// Debounces board buttons and switches for the MIO bus, keeps sticky
// press flags cleared by firmware, and packs a 32-bit status word.
module mio_input_debounce
  import mio_pkg::*;
#(
  parameter int unsigned NBTN       = MIO_NBTN,
  parameter int unsigned NSW        = MIO_NSW,
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned STABLE_CNT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_i,
  input  logic [NSW-1:0]  sw_i,
  input  logic            clr_we,
  input  logic [NBTN-1:0] clr_mask,
  output logic [NBTN-1:0] BTN_out,
  output logic [NSW-1:0]  SW_out,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] press_flag,
  output logic [31:0]     status_o
);

  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DivMax = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0]   div_q, div_d;
  logic            tick;
  logic [NBTN-1:0] btn_prev_q, btn_press_q, press_flag_q, press_flag_d;

  // Shared sample prescaler.
  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + 1'b1;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (btn_i[i]),
      .stable(BTN_out[i])
    );
  end

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_sw (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (sw_i[i]),
      .stable(SW_out[i])
    );
  end

  // Set dominates clear so a press landing on a clear write is kept.
  assign press_flag_d = btn_press_q | (press_flag_q & ~(clr_we ? clr_mask : '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      btn_prev_q   <= '0;
      btn_press_q  <= '0;
      press_flag_q <= '0;
    end else begin
      div_q        <= div_d;
      btn_prev_q   <= BTN_out;
      btn_press_q  <= BTN_out & ~btn_prev_q;
      press_flag_q <= press_flag_d;
    end
  end

  assign btn_press  = btn_press_q;
  assign press_flag = press_flag_q;

  always_comb begin
    status_o = '0;
    status_o[STAT_SW_LSB   +: NSW]  = SW_out;
    status_o[STAT_BTN_LSB  +: NBTN] = BTN_out;
    status_o[STAT_FLAG_LSB +: NBTN] = press_flag;
  end

endmodule

// File: tb/tb_mio_input_debounce.sv
// Bench for mio_input_debounce with a fast prescaler; a history-based
// reference model predicts every output on every cycle.
module tb_mio_input_debounce;

  localparam int unsigned DIV = 4;
  localparam int unsigned SC  = 3;
  localparam int unsigned NB  = 5;
  localparam int unsigned NS  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_i;
  logic [NS-1:0] sw_i;
  logic          clr_we;
  logic [NB-1:0] clr_mask;
  logic [NB-1:0] BTN_out;
  logic [NS-1:0] SW_out;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] press_flag;
  logic [31:0]   status_o;

  int n_cmp = 0;
  int n_bad = 0;

  mio_input_debounce #(
    .NBTN      (NB),
    .NSW       (NS),
    .SAMPLE_DIV(DIV),
    .STABLE_CNT(SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn_i),
    .sw_i      (sw_i),
    .clr_we    (clr_we),
    .clr_mask  (clr_mask),
    .BTN_out   (BTN_out),
    .SW_out    (SW_out),
    .btn_press (btn_press),
    .press_flag(press_flag),
    .status_o  (status_o)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last SC tick samples
  // taken since reset all disagree with the current level.
  logic [20:0]   m_d1, m_d2, m_stable, m_nstable, m_synced;
  logic [20:0]   m_hist [SC];
  int            m_hist_n, m_cyc;
  logic [NB-1:0] m_prev, m_press, m_flag;
  logic          m_tick, m_all;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_hist_n = 0; m_cyc = 0;
      m_prev = '0; m_press = '0; m_flag = '0;
      for (int j = 0; j < SC; j++) m_hist[j] = '0;
    end else begin
      m_tick = ((m_cyc % DIV) == DIV - 1);
      m_cyc++;
      m_synced = m_d2;
      m_d2 = m_d1;
      m_d1 = {btn_i, sw_i};
      m_nstable = m_stable;
      if (m_tick) begin
        for (int j = SC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_synced;
        if (m_hist_n < SC) m_hist_n++;
        for (int i = 0; i < 21; i++) begin
          m_all = (m_hist_n >= SC);
          for (int j = 0; j < SC; j++) if (m_hist[j][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) m_nstable[i] = ~m_stable[i];
        end
      end
      m_flag  = m_press | (m_flag & ~(clr_we ? clr_mask : '0));
      m_press = m_stable[20:16] & ~m_prev;
      m_prev  = m_stable[20:16];
      m_stable = m_nstable;
    end
  end

  function automatic logic [31:0] m_status();
    return {3'b000, m_flag, 3'b000, m_stable[20:16], m_stable[15:0]};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_i = 5'h1F; sw_i = 16'hFFFF; clr_we = 1'b0; clr_mask = '0;
    repeat (3) cyc();
    n_cmp++;
    if (status_o !== 32'h0 || btn_press !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_hold: status_o=%h btn_press=%h expected 0/0", status_o, btn_press);
    end
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL reset_model k=%0d: status_o=%h press=%h expected %h/%h", k, status_o,
                 btn_press, m_status(), m_press);
      end
      n_cmp++;
      if ((k <= 11 && (SW_out !== 16'h0 || BTN_out !== 5'h0)) ||
          (k >= 12 && (SW_out !== 16'hFFFF || BTN_out !== 5'h1F))) begin
        n_bad++;
        $display("FAIL reset_latency k=%0d: SW_out=%h BTN_out=%h expected %s", k, SW_out, BTN_out,
                 (k <= 11) ? "0000/00" : "ffff/1f");
      end
    end
  endtask

  task automatic test_glitch();
    btn_i = 5'h0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL glitch_settle: status_o=%h press=%h expected %h/%h", status_o, btn_press,
                 m_status(), m_press);
      end
    end
    clr_we = 1'b1; clr_mask = 5'h1F;
    cyc();
    clr_we = 1'b0; clr_mask = '0;
    btn_i[0] = 1'b1;
    for (int k = 0; k < 33; k++) begin
      if (k == 8) btn_i[0] = 1'b0;
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL glitch_model: status_o=%h press=%h expected %h/%h", status_o, btn_press,
                 m_status(), m_press);
      end
      n_cmp++;
      if (BTN_out[0] !== 1'b0 || btn_press[0] !== 1'b0 || press_flag[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch_reject: out/press/flag=%b%b%b expected 000", BTN_out[0],
                 btn_press[0], press_flag[0]);
      end
    end
  endtask

  task automatic test_clean_press();
    int rise = -1;
    int press_k = -1;
    int press_n = 0;
    btn_i[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL press_model: status_o=%h press=%h expected %h/%h", status_o, btn_press,
                 m_status(), m_press);
      end
      if (rise < 0 && BTN_out[2] === 1'b1) rise = k;
      if (btn_press[2] === 1'b1) begin
        press_n++;
        press_k = k;
      end
    end
    n_cmp++;
    if (rise < 11 || rise > 15) begin
      n_bad++;
      $display("FAIL press_latency: rise at cycle %0d expected 11..15", rise);
    end
    n_cmp++;
    if (press_n != 1 || press_k != rise + 1) begin
      n_bad++;
      $display("FAIL press_pulse: %0d pulses at cycle %0d expected 1 at %0d", press_n, press_k,
               rise + 1);
    end
    n_cmp++;
    if (press_flag[2] !== 1'b1 || status_o[26] !== 1'b1 || status_o[18] !== 1'b1) begin
      n_bad++;
      $display("FAIL press_flag: flag=%b st26=%b st18=%b expected 111", press_flag[2],
               status_o[26], status_o[18]);
    end
  endtask

  task automatic test_clear();
    btn_i[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL clear_model: status_o=%h press=%h expected %h/%h", status_o, btn_press,
                 m_status(), m_press);
      end
    end
    n_cmp++;
    if (press_flag !== 5'b00101) begin
      n_bad++;
      $display("FAIL clear_pre: press_flag=%b expected 00101", press_flag);
    end
    clr_we = 1'b1; clr_mask = 5'b00001;
    cyc();
    n_cmp++;
    if (press_flag !== 5'b00100) begin
      n_bad++;
      $display("FAIL clear_one: press_flag=%b expected 00100", press_flag);
    end
    clr_mask = 5'b00000;
    cyc();
    n_cmp++;
    if (press_flag !== 5'b00100) begin
      n_bad++;
      $display("FAIL clear_zero_mask: press_flag=%b expected 00100", press_flag);
    end
    clr_we = 1'b0; clr_mask = 5'h1F;
    cyc();
    n_cmp++;
    if (press_flag !== 5'b00100) begin
      n_bad++;
      $display("FAIL clear_no_we: press_flag=%b expected 00100", press_flag);
    end
    clr_mask = '0;
  endtask

  task automatic test_collision();
    bit hit = 1'b0;
    btn_i[3] = 1'b1;
    for (int k = 0; k < 22; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL collide_model: status_o=%h press=%h expected %h/%h", status_o, btn_press,
                 m_status(), m_press);
      end
      clr_we   = m_press[3];
      clr_mask = m_press[3] ? 5'b01000 : 5'b00000;
      if (m_press[3]) hit = 1'b1;
    end
    clr_we = 1'b0; clr_mask = '0;
    n_cmp++;
    if (!hit || press_flag[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_set_wins: hit=%0d press_flag[3]=%b expected 1/1", hit,
               press_flag[3]);
    end
  endtask

  task automatic test_reset_mid();
    btn_i[1] = 1'b1;
    repeat (8) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    n_cmp++;
    if (BTN_out[1] !== 1'b0 || press_flag !== 5'h0) begin
      n_bad++;
      $display("FAIL midreset_clear: BTN_out[1]=%b press_flag=%b expected 0/00000", BTN_out[1],
               press_flag);
    end
    for (int k = 1; k <= 15; k++) begin
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL midreset_model: status_o=%h press=%h expected %h/%h", status_o,
                 btn_press, m_status(), m_press);
      end
      n_cmp++;
      if ((k <= 11 && BTN_out[1] !== 1'b0) || (k >= 12 && BTN_out[1] !== 1'b1)) begin
        n_bad++;
        $display("FAIL midreset_requal k=%0d: BTN_out[1]=%b expected %0d", k, BTN_out[1],
                 (k >= 12));
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        hold  = $urandom_range(1, 20);
        sw_i  = 16'($urandom);
        btn_i = 5'($urandom);
      end
      hold--;
      clr_we   = ($urandom_range(0, 3) == 0);
      clr_mask = 5'($urandom);
      cyc();
      n_cmp++;
      if (status_o !== m_status() || btn_press !== m_press) begin
        n_bad++;
        $display("FAIL random_model k=%0d: status_o=%h press=%h expected %h/%h", k, status_o,
                 btn_press, m_status(), m_press);
      end
    end
    clr_we = 1'b0; clr_mask = '0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_clear();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
